sap2_prog_loader: RTL

Byte-stream program loader for the SAP2 mini: the writer side of its programming interface (prog, a, d). It accepts bytes over a valid/ready handshake, packs each pair into one 12-bit RAM word, and drives prog/a/d/we to fill RAM from address 0 upward. It holds the CPU in reset while loading and releases it when the image is complete.

---
 rtl/sap2_prog_loader_if.sv | 15 +
 rtl/sap2_prog_loader.sv | 104 ++++++++++
 2 files changed

// File: rtl/sap2_prog_loader_if.sv
// sap2_prog_loader_if: inbound byte stream and outbound RAM programming bus of the SAP2 loader.
interface sap2_prog_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 12
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              prog;
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] d;
   logic              we;
   modport master (output in_valid, in_data, input in_ready, prog, a, d, we);
   modport slave (input in_valid, in_data, output in_ready, prog, a, d, we);
endinterface

// File: rtl/sap2_prog_loader.sv
// sap2_prog_loader: packs byte pairs into 12-bit words, fills SAP2 RAM from 0 up, holds the CPU in reset meanwhile.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte (CSUM/HALT states).
module sap2_prog_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 12
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [8:0] word_count,
   sap2_prog_loader_if.slave bus,
   output logic       cpu_clr,
   output logic       busy,
   output logic       done,
   output logic       err
);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HI, LO, WRITE, RELEASE, DONE, CSUM, HALT} state_t;
   localparam state_t LAST = CSUM;
`else
   typedef enum logic [2:0] {IDLE, HI, LO, WRITE, RELEASE, DONE} state_t;
   localparam state_t LAST = RELEASE;
`endif
   state_t            state, nxt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] word;
   logic [3:0]        nib;
   logic [8:0]        rem;
   logic [7:0]        sum;
   logic              rdy, prog, we, xfer, idle_like, csum_st, csum_nxt, bad_sum;
   assign bus.in_ready = rdy;
   assign bus.prog = prog;
   assign bus.a = addr;
   assign bus.d = word;
   assign bus.we = we;
   assign xfer = bus.in_valid && rdy;
`ifdef LOADER_CHECKSUM_EN
   assign idle_like = state == IDLE || state == DONE || state == HALT;
   assign csum_st = state == CSUM;
   assign csum_nxt = nxt == CSUM;
`else
   assign idle_like = state == IDLE || state == DONE;
   assign csum_st = 1'b0;
   assign csum_nxt = 1'b0;
`endif
   assign bad_sum = csum_st && xfer && bus.in_data != sum;
   always_comb begin
      nxt = state;
      case (state)
         HI:      nxt = xfer ? LO : HI;
         LO:      nxt = xfer ? WRITE : LO;
         WRITE:   nxt = rem == 9'd1 ? LAST : HI;
         RELEASE: nxt = DONE;
`ifdef LOADER_CHECKSUM_EN
         CSUM:    nxt = xfer ? (bad_sum ? HALT : RELEASE) : CSUM;
`endif
         default: nxt = start && idle_like ? HI : state;
      endcase
   end
   always_ff @(posedge clk or posedge clr)
      if (clr) state <= IDLE;
      else state <= nxt;
   // outputs are decoded from the next state so they are registered yet aligned with the state they describe
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         addr    <= '0;
         word    <= '0;
         nib     <= '0;
         rem     <= '0;
         sum     <= '0;
         err     <= 1'b0;
         rdy     <= 1'b0;
         prog    <= 1'b0;
         we      <= 1'b0;
         cpu_clr <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         if (start && idle_like) begin
            addr <= '0;
            rem  <= word_count == 9'd0 || word_count > 9'd256 ? 9'd256 : word_count;
            sum  <= '0;
            err  <= 1'b0;
         end
         if (xfer) sum <= sum + bus.in_data;
         if (state == HI && xfer) begin
            nib <= bus.in_data[3:0];
            if (bus.in_data[7:4] != 4'd0) err <= 1'b1;
         end
         if (state == LO && xfer) word <= {nib, bus.in_data};
         if (state == WRITE) begin
            addr <= addr + ADDR_W'(1);
            rem  <= rem - 9'd1;
         end
         if (bad_sum) err <= 1'b1;
         rdy     <= nxt == HI || nxt == LO || csum_nxt;
         prog    <= nxt == HI || nxt == LO || nxt == WRITE || csum_nxt;
         we      <= nxt == WRITE;
         cpu_clr <= nxt != DONE;
         busy    <= nxt == HI || nxt == LO || nxt == WRITE || nxt == RELEASE || csum_nxt;
         done    <= nxt == DONE;
      end
   end
endmodule
